// File: rtl/piso_pkg.sv
// Shared types and JK input codes for the JK-based parallel-in serial-out shifter.
package piso_pkg;

    typedef enum logic [0:0] {
        IDLE,
        SHIFT
    } state_e;

    // {J, K} codes applied to a JK cell
    localparam logic [1:0] HOLD = 2'b00;
    localparam logic [1:0] RST0 = 2'b01;
    localparam logic [1:0] SET1 = 2'b10;
    localparam logic [1:0] TOG  = 2'b11;

endpackage

// File: rtl/jk_ff_arn.sv
// JK flip-flop with asynchronous active-low clear and complementary output.
module jk_ff_arn
    import piso_pkg::*;
(
    input  logic clk_i,
    input  logic rst_ni,
    input  logic j_i,
    input  logic k_i,
    output logic q_o,
    output logic qb_o
);

    logic q_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            q_q <= 1'b0;
        end else begin
            case ({j_i, k_i})
                HOLD:    q_q <= q_q;
                RST0:    q_q <= 1'b0;
                SET1:    q_q <= 1'b1;
                TOG:     q_q <= ~q_q;
                default: q_q <= q_q;
            endcase
        end
    end

    assign q_o  = q_q;
    assign qb_o = ~q_q;

endmodule

// File: rtl/piso_using_jk.sv
// Parallel-in serial-out shifter built from JK cells; sends words MSB first with
// a valid/ready load handshake and back-to-back reload on the last-bit cycle.
module piso_using_jk
    import piso_pkg::*;
#(
    parameter int unsigned WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_valid,
    input  logic [WIDTH-1:0] pdata,
    output logic             load_ready,
    output logic             sout,
    output logic             sout_valid,
    output logic             sout_last
);

    localparam int unsigned    CntW   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CntW-1:0] CntMax = CntW'(WIDTH - 1);

    state_e            state_q, state_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]  sreg_q;
    logic [WIDTH-1:0]  sreg_b;
    logic              last, accept, do_shift, do_clear;
    logic              unused_qb;

    assign last       = (state_q == SHIFT) && (cnt_q == CntMax);
    assign load_ready = (state_q == IDLE) || last;
    assign accept     = load_valid && load_ready;
    assign do_shift   = (state_q == SHIFT) && !last;
    assign do_clear   = last && !accept;

    for (genvar i = 0; i < WIDTH; i++) begin : g_cell
        logic       shift_j, shift_k;
        logic [1:0] jk;

        // The complement output of the neighbour supplies K directly when shifting
        if (i == 0) begin : g_lsb
            assign shift_j = 1'b0;
            assign shift_k = 1'b1;
        end else begin : g_bit
            assign shift_j = sreg_q[i-1];
            assign shift_k = sreg_b[i-1];
        end

        always_comb begin
            jk = HOLD;
            if (accept) begin
                jk = {pdata[i], ~pdata[i]};
            end else if (do_shift) begin
                jk = {shift_j, shift_k};
            end else if (do_clear) begin
                jk = RST0;
            end
        end

        jk_ff_arn u_cell (
            .clk_i  (clk),
            .rst_ni (rst),
            .j_i    (jk[1]),
            .k_i    (jk[0]),
            .q_o    (sreg_q[i]),
            .qb_o   (sreg_b[i])
        );
    end

    assign unused_qb = sreg_b[WIDTH-1];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = SHIFT;
                    cnt_d   = '0;
                end
            end
            SHIFT: begin
                if (last) begin
                    state_d = accept ? SHIFT : IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    assign sout_valid = (state_q == SHIFT);
    assign sout       = sout_valid && sreg_q[WIDTH-1];
    assign sout_last  = last;

endmodule

// File: tb/tb_piso_using_jk.sv
// Self-checking bench for piso_using_jk at WIDTH 4 and 8 against a bits-remaining model.
module tb_piso_using_jk;

    logic       clk;
    logic       rst;
    logic       lv4, rdy4, so4, sv4, sl4;
    logic [3:0] pd4;
    logic       lv8, rdy8, so8, sv8, sl8;
    logic [7:0] pd8;

    int tests_run    = 0;
    int tests_failed = 0;

    // Model: bits still to send of the current word (0 = idle) and the word itself
    int          m_left [2];
    logic [31:0] m_word [2];

    piso_using_jk #(.WIDTH(4)) dut4 (
        .clk        (clk),
        .rst        (rst),
        .load_valid (lv4),
        .pdata      (pd4),
        .load_ready (rdy4),
        .sout       (so4),
        .sout_valid (sv4),
        .sout_last  (sl4)
    );

    piso_using_jk #(.WIDTH(8)) dut8 (
        .clk        (clk),
        .rst        (rst),
        .load_valid (lv8),
        .pdata      (pd8),
        .load_ready (rdy8),
        .sout       (so8),
        .sout_valid (sv8),
        .sout_last  (sl8)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int wid(input int d);
        return (d == 0) ? 4 : 8;
    endfunction

    // {sout, sout_valid, sout_last, load_ready}
    function automatic logic [3:0] obs(input int d);
        return (d == 0) ? {so4, sv4, sl4, rdy4} : {so8, sv8, sl8, rdy8};
    endfunction

    function automatic logic [3:0] exp_out(input int d);
        int   n;
        logic b;
        n = m_left[d];
        if (n == 0) return 4'b0001;
        b = m_word[d][n-1];
        return {b, 1'b1, (n == 1), (n == 1)};
    endfunction

    // Present inputs for the coming edge, advance the model, land on the next negedge
    task automatic drive(input int d, input logic lv, input logic [31:0] pd, output logic acc);
        acc = lv && (m_left[d] <= 1);
        if (d == 0) begin
            lv4 = lv;
            pd4 = pd[3:0];
        end else begin
            lv8 = lv;
            pd8 = pd[7:0];
        end
        if (acc) begin
            m_left[d] = wid(d);
            m_word[d] = pd;
        end else if (m_left[d] > 0) begin
            m_left[d] = m_left[d] - 1;
        end
        @(negedge clk);
    endtask

    task automatic model_reset();
        m_left[0] = 0;
        m_left[1] = 0;
    endtask

    task automatic test_reset();
        logic [3:0] got;
        #1;
        for (int c = 0; c < 4; c++) begin
            for (int d = 0; d < 2; d++) begin
                got = obs(d);
                tests_run++;
                if (got !== 4'b0001) begin
                    tests_failed++;
                    $display("FAIL reset d%0d c%0d: got %b want 0001", d, c, got);
                end
            end
            @(negedge clk);
        end
        rst = 1'b1;
    endtask

    task automatic test_single_word();
        logic [3:0] got, want, bits, lasts;
        logic       acc;
        bits  = '0;
        lasts = '0;
        for (int c = 0; c < 6; c++) begin
            got  = obs(0);
            want = exp_out(0);
            tests_run++;
            if (got !== want) begin
                tests_failed++;
                $display("FAIL single c%0d: got %b want %b", c, got, want);
            end
            if (c >= 1 && c <= 4) begin
                bits  = {bits[2:0], got[3]};
                lasts = {lasts[2:0], got[1]};
            end
            drive(0, (c == 0), (c == 0) ? 32'hB : $urandom, acc);
        end
        tests_run++;
        if (bits !== 4'b1011 || lasts !== 4'b0001) begin
            tests_failed++;
            $display("FAIL single_seq: got bits %b last %b want 1011 0001", bits, lasts);
        end
    endtask

    task automatic test_back_to_back();
        logic [3:0] got, want;
        logic [7:0] bits;
        logic [9:0] rdys;
        logic       acc;
        logic [31:0] q[$];
        q    = '{32'hC, 32'h6};
        bits = '0;
        rdys = '0;
        for (int c = 0; c < 10; c++) begin
            got  = obs(0);
            want = exp_out(0);
            tests_run++;
            if (got !== want) begin
                tests_failed++;
                $display("FAIL b2b c%0d: got %b want %b", c, got, want);
            end
            if (c >= 1 && c <= 8) bits = {bits[6:0], got[3]};
            rdys = {rdys[8:0], got[0]};
            drive(0, q.size() > 0, (q.size() > 0) ? q[0] : 32'h0, acc);
            if (acc) void'(q.pop_front());
        end
        tests_run++;
        if (bits !== 8'b1100_0110 || rdys !== 10'b1000100011) begin
            tests_failed++;
            $display("FAIL b2b_seq: got bits %b ready %b want 11000110 1000100011", bits, rdys);
        end
    endtask

    task automatic test_busy_ignore();
        logic [3:0] got, want, bits;
        logic       acc, lv;
        bits = '0;
        for (int c = 0; c < 12; c++) begin
            got  = obs(0);
            want = exp_out(0);
            tests_run++;
            if (got !== want) begin
                tests_failed++;
                $display("FAIL busy c%0d: got %b want %b", c, got, want);
            end
            if (c >= 1 && c <= 4) bits = {bits[2:0], got[3]};
            lv = (c == 0) || (c == 2) || (c == 6);
            drive(0, lv, (c == 0) ? 32'h5 : 32'hF, acc);
        end
        tests_run++;
        if (bits !== 4'b0101) begin
            tests_failed++;
            $display("FAIL busy_seq: got %b want 0101", bits);
        end
    endtask

    task automatic test_midword_reset();
        logic [3:0] got, want, bits;
        logic       acc;
        drive(0, 1'b1, 32'hA, acc);
        for (int c = 0; c < 2; c++) begin
            got  = obs(0);
            want = exp_out(0);
            tests_run++;
            if (got !== want) begin
                tests_failed++;
                $display("FAIL mrst_pre c%0d: got %b want %b", c, got, want);
            end
            if (c == 0) drive(0, 1'b0, 32'h0, acc);
        end
        #2;
        rst = 1'b0;
        model_reset();
        #1;
        got = obs(0);
        tests_run++;
        if (got !== 4'b0001) begin
            tests_failed++;
            $display("FAIL mrst_async: got %b want 0001", got);
        end
        lv4 = 1'b1;
        pd4 = 4'hF;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            got = obs(0);
            tests_run++;
            if (got !== 4'b0001) begin
                tests_failed++;
                $display("FAIL mrst_hold c%0d: got %b want 0001", c, got);
            end
        end
        lv4 = 1'b0;
        rst = 1'b1;
        bits = '0;
        for (int c = 0; c < 6; c++) begin
            got  = obs(0);
            want = exp_out(0);
            tests_run++;
            if (got !== want) begin
                tests_failed++;
                $display("FAIL mrst_post c%0d: got %b want %b", c, got, want);
            end
            if (c >= 1 && c <= 4) bits = {bits[2:0], got[3]};
            drive(0, (c == 0), 32'h1, acc);
        end
        tests_run++;
        if (bits !== 4'b0001) begin
            tests_failed++;
            $display("FAIL mrst_seq: got %b want 0001", bits);
        end
    endtask

    task automatic test_width8();
        logic [3:0]  got, want;
        logic [7:0]  words [3];
        logic [31:0] q[$];
        logic        acc, eb;
        int          nvalid;
        words  = '{8'hA5, 8'h00, 8'hFF};
        q      = '{32'hA5, 32'h00, 32'hFF};
        nvalid = 0;
        for (int c = 0; c < 80; c++) begin
            got  = obs(1);
            want = exp_out(1);
            tests_run++;
            if (got !== want) begin
                tests_failed++;
                $display("FAIL w8 c%0d: got %b want %b", c, got, want);
            end
            if (got[2] === 1'b1 && nvalid < 24) begin
                eb = words[nvalid / 8][7 - (nvalid % 8)];
                tests_run++;
                if (got[3] !== eb || got[1] !== ((nvalid % 8) == 7)) begin
                    tests_failed++;
                    $display("FAIL w8_bit %0d: got sout %b last %b want %b %b",
                             nvalid, got[3], got[1], eb, ((nvalid % 8) == 7));
                end
                nvalid++;
            end
            if (q.size() == 0 && m_left[1] == 0) break;
            drive(1, (q.size() > 0) && ($urandom_range(0, 2) != 0),
                  (q.size() > 0) ? q[0] : 32'h0, acc);
            if (acc) void'(q.pop_front());
        end
        tests_run++;
        if (nvalid != 24) begin
            tests_failed++;
            $display("FAIL w8_count: got %0d valid bits want 24", nvalid);
        end
    endtask

    task automatic test_random(input int d);
        logic [3:0]  got, want;
        logic        acc, lv;
        logic [31:0] pd;
        lv = 1'b0;
        pd = '0;
        for (int c = 0; c < 120; c++) begin
            got  = obs(d);
            want = exp_out(d);
            tests_run++;
            if (got !== want) begin
                tests_failed++;
                $display("FAIL rand d%0d c%0d: got %b want %b", d, c, got, want);
            end
            // A presented but unaccepted word stays on the bus unchanged
            if (!lv) begin
                lv = ($urandom_range(0, 3) != 0) && (c < 110);
                pd = $urandom;
            end
            drive(d, lv, pd, acc);
            if (acc) lv = 1'b0;
        end
        drive(d, 1'b0, 32'h0, acc);
    endtask

    initial begin
        rst = 1'b0;
        lv4 = 1'b0;
        pd4 = '0;
        lv8 = 1'b0;
        pd8 = '0;
        m_word[0] = '0;
        m_word[1] = '0;
        model_reset();
        test_reset();
        test_single_word();
        test_back_to_back();
        test_busy_ignore();
        test_midword_reset();
        test_width8();
        test_random(0);
        test_random(1);
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
